// File: rtl/l1d_dat_ram_sched_pkg.sv
// Shared types and constants for the L1D data-RAM pipe scheduler.
// The payload struct widths match the scheduler's default parameters.
package l1d_dat_ram_sched_pkg;

    localparam int unsigned L1D_ADDR_W = 10;
    localparam int unsigned L1D_DATA_W = 128;
    localparam int unsigned L1D_BE_W   = 16;
    localparam int unsigned L1D_ID_W   = 4;
    localparam int unsigned L1D_BEATS  = 4;
    localparam int unsigned L1D_BEAT_W = $clog2(L1D_BEATS);

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [1:0] {
        SRC_WR = 2'd0,
        SRC_EV = 2'd1,
        SRC_LF = 2'd2
    } sched_src_e;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLfBurst = 2'd1,
        StEvBurst = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [L1D_ADDR_W-1:0] addr;
        logic [L1D_BEAT_W-1:0] beat;
        logic [L1D_DATA_W-1:0] data;
        logic [L1D_BE_W-1:0]   be;
        logic [L1D_ID_W-1:0]   id;
        logic                  rw_type;
        logic                  downstream;
        sched_src_e            src;
    } pack_sched_pipe_pld;

endpackage

// File: rtl/l1d_dat_ram_sched_starve_cnt.sv
// Per-requester blocked-cycle counter; saturates at the limit and flags starvation there.
module l1d_dat_ram_sched_starve_cnt #(
    parameter int unsigned STARVE_LIMIT = 8,
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vld,
    input  logic hs,
    output logic starving
);

    logic [CNT_W-1:0] cnt_q;

    assign starving = (cnt_q == CNT_W'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!vld || hs) begin
            cnt_q <= '0;
        end else if (!starving) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/l1d_dat_ram_sched.sv
// Shares the single L1D data-RAM pipe between store writes, evict readouts and linefills,
// with burst locking for line operations and a one-entry registered output stage.
module l1d_dat_ram_sched
    import l1d_dat_ram_sched_pkg::*;
#(
    parameter int unsigned ADDR_W       = L1D_ADDR_W,
    parameter int unsigned DATA_W       = L1D_DATA_W,
    parameter int unsigned BE_W         = L1D_BE_W,
    parameter int unsigned ID_W         = L1D_ID_W,
    parameter int unsigned BEATS        = L1D_BEATS,
    parameter int unsigned STARVE_LIMIT = 8,
    localparam int unsigned BEAT_W      = $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              wr_vld,
    output logic              wr_rdy,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BEAT_W-1:0] wr_beat,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [ID_W-1:0]   wr_id,

    input  logic              evict_vld,
    output logic              evict_rdy,
    input  logic [ADDR_W-1:0] evict_addr,
    input  logic [ID_W-1:0]   evict_id,

    input  logic              lf_vld,
    output logic              lf_rdy,
    input  logic [ADDR_W-1:0] lf_addr,
    input  logic [DATA_W-1:0] lf_data,

    output logic              pipe_vld,
    input  logic              pipe_rdy,
    output logic [ADDR_W-1:0] pipe_addr,
    output logic [BEAT_W-1:0] pipe_beat,
    output logic [DATA_W-1:0] pipe_data,
    output logic [BE_W-1:0]   pipe_be,
    output logic [ID_W-1:0]   pipe_id,
    output logic              pipe_rw_type,
    output logic              pipe_downstream,
    output logic [1:0]        pipe_src,
    output logic              sched_busy
);

    sched_state_e       state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [ADDR_W-1:0]  ev_addr_q;
    logic [ID_W-1:0]    ev_id_q;
    logic               pipe_vld_q;
    pack_sched_pipe_pld pld_q, pld_d;

    logic accept;
    logic gnt_wr, gnt_ev, gnt_lf, ev_beat, issue, burst_beat;
    logic starve_wr, starve_ev, starve_lf;

    assign accept = !pipe_vld_q || pipe_rdy;

    l1d_dat_ram_sched_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve_wr (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld      (wr_vld),
        .hs       (wr_vld && wr_rdy),
        .starving (starve_wr)
    );

    l1d_dat_ram_sched_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve_ev (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld      (evict_vld),
        .hs       (evict_vld && evict_rdy),
        .starving (starve_ev)
    );

    l1d_dat_ram_sched_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve_lf (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld      (lf_vld),
        .hs       (lf_vld && lf_rdy),
        .starving (starve_lf)
    );

    // Grant: starving requesters win first in base order, bursts own the pipe outright.
    always_comb begin
        gnt_wr  = 1'b0;
        gnt_ev  = 1'b0;
        gnt_lf  = 1'b0;
        ev_beat = 1'b0;
        if (accept) begin
            unique case (state_q)
                StIdle: begin
                    if (wr_vld && starve_wr)          gnt_wr = 1'b1;
                    else if (evict_vld && starve_ev)  gnt_ev = 1'b1;
                    else if (lf_vld && starve_lf)     gnt_lf = 1'b1;
                    else if (wr_vld)                  gnt_wr = 1'b1;
                    else if (evict_vld)               gnt_ev = 1'b1;
                    else if (lf_vld)                  gnt_lf = 1'b1;
                end
                StLfBurst: gnt_lf  = lf_vld;
                StEvBurst: ev_beat = 1'b1;
                default: ;
            endcase
        end
    end

    assign burst_beat = gnt_ev || ev_beat || gnt_lf;
    assign issue      = gnt_wr || burst_beat;

    // beat_q is zero whenever the scheduler is idle, so it also supplies beat 0 of a new burst.
    always_comb begin
        pld_d = pld_q;
        if (gnt_wr) begin
            pld_d.addr       = wr_addr;
            pld_d.beat       = wr_beat;
            pld_d.data       = wr_data;
            pld_d.be         = wr_be;
            pld_d.id         = wr_id;
            pld_d.rw_type    = RW_WRITE;
            pld_d.downstream = 1'b0;
            pld_d.src        = SRC_WR;
        end else if (gnt_ev || ev_beat) begin
            pld_d.addr       = gnt_ev ? evict_addr : ev_addr_q;
            pld_d.beat       = beat_q;
            pld_d.data       = '0;
            pld_d.be         = '1;
            pld_d.id         = gnt_ev ? evict_id : ev_id_q;
            pld_d.rw_type    = RW_READ;
            pld_d.downstream = 1'b1;
            pld_d.src        = SRC_EV;
        end else if (gnt_lf) begin
            pld_d.addr       = lf_addr;
            pld_d.beat       = beat_q;
            pld_d.data       = lf_data;
            pld_d.be         = '1;
            pld_d.id         = '0;
            pld_d.rw_type    = RW_WRITE;
            pld_d.downstream = 1'b1;
            pld_d.src        = SRC_LF;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        if (burst_beat) begin
            if (beat_q == BEAT_W'(BEATS - 1)) begin
                beat_d  = '0;
                state_d = StIdle;
            end else begin
                beat_d  = beat_q + BEAT_W'(1);
                state_d = gnt_lf ? StLfBurst : StEvBurst;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            ev_addr_q  <= '0;
            ev_id_q    <= '0;
            pipe_vld_q <= 1'b0;
            pld_q      <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (gnt_ev) begin
                ev_addr_q <= evict_addr;
                ev_id_q   <= evict_id;
            end
            if (accept) begin
                pipe_vld_q <= issue;
                pld_q      <= pld_d;
            end
        end
    end

    assign wr_rdy          = gnt_wr;
    assign evict_rdy       = gnt_ev;
    assign lf_rdy          = gnt_lf;
    assign sched_busy      = (state_q != StIdle);
    assign pipe_vld        = pipe_vld_q;
    assign pipe_addr       = pld_q.addr;
    assign pipe_beat       = pld_q.beat;
    assign pipe_data       = pld_q.data;
    assign pipe_be         = pld_q.be;
    assign pipe_id         = pld_q.id;
    assign pipe_rw_type    = pld_q.rw_type;
    assign pipe_downstream = pld_q.downstream;
    assign pipe_src        = pld_q.src;

endmodule
